// File: rtl/msix_pkg.sv
// msix_pkg: shared constants, sender state type and helper functions for
// the MSI-X table / PBA endpoint.
package msix_pkg;

  localparam int unsigned MAX_VECTORS  = 2048;
  localparam int unsigned VEC_W        = 11;
  localparam int unsigned ENTRY_STRIDE = 16;
  localparam int unsigned PBA_STRIDE   = 8;

  // Dword offsets within one table entry
  localparam logic [1:0] ADDR_LO = 2'd0;
  localparam logic [1:0] ADDR_HI = 2'd1;
  localparam logic [1:0] DATA    = 2'd2;
  localparam logic [1:0] VCTRL   = 2'd3;

  localparam int unsigned VCTRL_MASK_BIT = 0;

  typedef enum logic {
    IDLE,
    WAIT_ACK
  } sender_state_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [VEC_W-1:0] lowest_set(input logic [MAX_VECTORS-1:0] v);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int unsigned i = MAX_VECTORS; i > 0; i--) begin
      if (v[i-1]) r = VEC_W'(i - 1);
    end
    return r;
  endfunction

  // Byte-lane merge of write data into an existing dword.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/msix_table.sv
// msix_table: MSI-X table and Pending Bit Array behind a PCIe BAR.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   bar_addr/bar_index      BAR access address and BAR number
//   bar_wr_data/en/be       dword write with byte enables
//   bar_rd_en               read strobe (no side effects)
//   bar_rd_data             combinational read data
//   bar_access_match        access hits table or PBA window
//   msix_enable             capability MSI-X Enable
//   msix_function_mask      capability Function Mask
//   msix_interrupt/vector   request to PCIe core
//   msix_interrupt_ack      one-cycle acknowledge from core
// Interrupt sources call the task trigger_interrupt(vector).
module msix_table
  import msix_pkg::*;
#(
  parameter int unsigned NUM_MSIX          = 1,
  parameter logic [2:0]  MSIX_TABLE_BIR    = 3'd0,
  parameter logic [31:0] MSIX_TABLE_OFFSET = 32'h0,
  parameter logic [2:0]  MSIX_PBA_BIR      = 3'd0,
  parameter logic [31:0] MSIX_PBA_OFFSET   = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] bar_addr,
  input  logic [2:0]  bar_index,
  input  logic [31:0] bar_wr_data,
  input  logic        bar_wr_en,
  input  logic [3:0]  bar_wr_be,
  input  logic        bar_rd_en,
  output logic [31:0] bar_rd_data,
  output logic        bar_access_match,
  input  logic        msix_enable,
  input  logic        msix_function_mask,
  output logic        msix_interrupt,
  output logic [10:0] msix_vector,
  input  logic        msix_interrupt_ack
);

  localparam int unsigned IW     = (NUM_MSIX > 1) ? $clog2(NUM_MSIX) : 1;
  localparam int unsigned PBA_QW = (NUM_MSIX + 63) / 64;
  localparam int unsigned PBA_DW = 2 * PBA_QW;
  localparam int unsigned PW     = (PBA_DW > 1) ? $clog2(PBA_DW) : 1;

  localparam logic [32:0] TBL_LO = {1'b0, MSIX_TABLE_OFFSET};
  localparam logic [32:0] TBL_HI = TBL_LO + 33'(ENTRY_STRIDE * NUM_MSIX);
  localparam logic [32:0] PBA_LO = {1'b0, MSIX_PBA_OFFSET};
  localparam logic [32:0] PBA_HI = PBA_LO + 33'(PBA_STRIDE * PBA_QW);

  // Table storage
  logic [31:0]         addr_lo_q [NUM_MSIX];
  logic [31:0]         addr_hi_q [NUM_MSIX];
  logic [31:0]         data_q    [NUM_MSIX];
  logic [NUM_MSIX-1:0] mask_q;

  logic [NUM_MSIX-1:0] pending_q, pending_d;
  sender_state_e       state_q, state_d;
  logic                irq_q, irq_d;
  logic [VEC_W-1:0]    vec_q, vec_d;

  // Trigger requests from the task are toggles; a bit differing from its
  // seen copy marks a new request for one cycle, so the task never has to
  // share a driver with the clocked logic.
  logic [NUM_MSIX-1:0] trig_tog = '0;
  logic [NUM_MSIX-1:0] trig_seen_q;
  logic [NUM_MSIX-1:0] trig_set;

  task automatic trigger_interrupt(input logic [10:0] vector);
    if (32'(vector) < NUM_MSIX) trig_tog[vector[IW-1:0]] = ~trig_tog[vector[IW-1:0]];
  endtask

  assign trig_set = trig_tog ^ trig_seen_q;

  // Address decode
  logic          tbl_hit, pba_hit;
  logic [31:0]   tbl_rel, pba_rel;
  logic [IW-1:0] idx;
  logic [1:0]    dword;
  logic [PW-1:0] pba_k;
  logic [PBA_QW*64-1:0] pend_pad;
  logic [31:0]   pba_word;

  assign tbl_hit = (bar_index == MSIX_TABLE_BIR) &&
                   ({1'b0, bar_addr} >= TBL_LO) && ({1'b0, bar_addr} < TBL_HI);
  assign pba_hit = (bar_index == MSIX_PBA_BIR) &&
                   ({1'b0, bar_addr} >= PBA_LO) && ({1'b0, bar_addr} < PBA_HI);
  assign bar_access_match = tbl_hit || pba_hit;

  assign tbl_rel  = bar_addr - MSIX_TABLE_OFFSET;
  assign pba_rel  = bar_addr - MSIX_PBA_OFFSET;
  assign idx      = tbl_rel[4 +: IW];
  assign dword    = bar_addr[3:2];
  assign pba_k    = pba_rel[2 +: PW];
  assign pend_pad = (PBA_QW*64)'(pending_q);
  assign pba_word = 32'(pend_pad >> {pba_k, 5'd0});

  always_comb begin
    bar_rd_data = '0;
    if (tbl_hit) begin
      case (dword)
        ADDR_LO: bar_rd_data = addr_lo_q[idx];
        ADDR_HI: bar_rd_data = addr_hi_q[idx];
        DATA:    bar_rd_data = data_q[idx];
        default: bar_rd_data = {31'd0, mask_q[idx]};
      endcase
    end else if (pba_hit) begin
      bar_rd_data = pba_word;
    end
  end

  // Table writes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_MSIX; i++) begin
        addr_lo_q[i] <= '0;
        addr_hi_q[i] <= '0;
        data_q[i]    <= '0;
      end
      mask_q <= '1;
    end else if (bar_wr_en && tbl_hit) begin
      case (dword)
        ADDR_LO: addr_lo_q[idx] <= be_merge(addr_lo_q[idx], bar_wr_data, bar_wr_be) & 32'hFFFF_FFFC;
        ADDR_HI: addr_hi_q[idx] <= be_merge(addr_hi_q[idx], bar_wr_data, bar_wr_be);
        DATA:    data_q[idx]    <= be_merge(data_q[idx], bar_wr_data, bar_wr_be);
        default: if (bar_wr_be[0]) mask_q[idx] <= bar_wr_data[VCTRL_MASK_BIT];
      endcase
    end
  end

  // Sender
  logic [NUM_MSIX-1:0] eligible;
  logic [VEC_W-1:0]    sel_vec;

  assign eligible = pending_q & ~mask_q;
  assign sel_vec  = lowest_set(MAX_VECTORS'(eligible));

  always_comb begin
    state_d   = state_q;
    irq_d     = irq_q;
    vec_d     = vec_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (msix_enable && !msix_function_mask && (|eligible)) begin
          state_d = WAIT_ACK;
          irq_d   = 1'b1;
          vec_d   = sel_vec;
        end
      end
      default: begin
        if (msix_interrupt_ack) begin
          state_d = IDLE;
          irq_d   = 1'b0;
          pending_d[vec_q[IW-1:0]] = 1'b0;
        end
      end
    endcase
    // A new trigger overrides a same-cycle clear
    pending_d = pending_d | trig_set;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      irq_q       <= 1'b0;
      vec_q       <= '0;
      pending_q   <= '0;
      trig_seen_q <= trig_tog;
    end else begin
      state_q     <= state_d;
      irq_q       <= irq_d;
      vec_q       <= vec_d;
      pending_q   <= pending_d;
      trig_seen_q <= trig_tog;
    end
  end

  assign msix_interrupt = irq_q;
  assign msix_vector    = vec_q;

  logic unused_bits;
  assign unused_bits = &{1'b0, bar_rd_en, bar_addr[1:0], tbl_rel, pba_rel, vec_q};

endmodule

// File: tb/tb_msix_table.sv
module tb_msix_table;

  localparam int unsigned N = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] bar_addr;
  logic [2:0]  bar_index;
  logic [31:0] bar_wr_data;
  logic        bar_wr_en;
  logic [3:0]  bar_wr_be;
  logic        bar_rd_en;
  logic [31:0] bar_rd_data;
  logic        bar_access_match;
  logic        msix_enable;
  logic        msix_function_mask;
  logic        msix_interrupt;
  logic [10:0] msix_vector;
  logic        msix_interrupt_ack;

  always #5 clk = ~clk;

  msix_table #(
    .NUM_MSIX         (N),
    .MSIX_TABLE_BIR   (3'd0),
    .MSIX_TABLE_OFFSET(32'h0000_1000),
    .MSIX_PBA_BIR     (3'd0),
    .MSIX_PBA_OFFSET  (32'h0000_2000)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .bar_addr          (bar_addr),
    .bar_index         (bar_index),
    .bar_wr_data       (bar_wr_data),
    .bar_wr_en         (bar_wr_en),
    .bar_wr_be         (bar_wr_be),
    .bar_rd_en         (bar_rd_en),
    .bar_rd_data       (bar_rd_data),
    .bar_access_match  (bar_access_match),
    .msix_enable       (msix_enable),
    .msix_function_mask(msix_function_mask),
    .msix_interrupt    (msix_interrupt),
    .msix_vector       (msix_vector),
    .msix_interrupt_ack(msix_interrupt_ack)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic        match;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive a read, queue its expectation, then sample and score it.
  task automatic rd(input string tag, input logic [31:0] addr,
                    input logic [31:0] exp_data, input logic exp_match);
    exp_t e;
    bar_addr  = addr;
    bar_index = 3'd0;
    bar_rd_en = 1'b1;
    sb.push_back('{tag, exp_data, exp_match});
    #1;
    e = sb.pop_front();
    check({e.tag, " data"}, bar_rd_data, e.data);
    check({e.tag, " match"}, 32'(bar_access_match), 32'(e.match));
    bar_rd_en = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    @(negedge clk);
    bar_addr    = addr;
    bar_index   = 3'd0;
    bar_wr_data = data;
    bar_wr_be   = be;
    bar_wr_en   = 1'b1;
    @(negedge clk);
    bar_wr_en   = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_irq(input string tag, input logic [10:0] exp_vec);
    int k;
    k = 0;
    while (!msix_interrupt && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, " irq"}, 32'(msix_interrupt), 32'd1);
    check({tag, " vec"}, 32'(msix_vector), 32'(exp_vec));
  endtask

  task automatic ack();
    @(negedge clk);
    msix_interrupt_ack = 1'b1;
    @(negedge clk);
    msix_interrupt_ack = 1'b0;
  endtask

  initial begin
    reset_n            = 1'b0;
    bar_addr           = '0;
    bar_index          = '0;
    bar_wr_data        = '0;
    bar_wr_en          = 1'b0;
    bar_wr_be          = '0;
    bar_rd_en          = 1'b0;
    msix_enable        = 1'b1;
    msix_function_mask = 1'b0;
    msix_interrupt_ack = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst irq", 32'(msix_interrupt), 32'd0);
    check("rst vec", 32'(msix_vector), 32'd0);
    rd("rst e0 alo", 32'h1000, 32'h0, 1'b1);
    rd("rst e0 ahi", 32'h1004, 32'h0, 1'b1);
    rd("rst e0 dat", 32'h1008, 32'h0, 1'b1);
    rd("rst e0 vct", 32'h100C, 32'h1, 1'b1);
    rd("rst pba",    32'h2000, 32'h0, 1'b1);

    // Register access
    wr(32'h1000, 32'hFEE0_1234, 4'b0011);
    rd("be merge", 32'h1000, 32'h0000_1234, 1'b1);
    rd("tbl end", 32'h1040, 32'h0, 1'b0);
    wr(32'h1008, 32'hDEAD_BEEF, 4'b0000);
    rd("be zero", 32'h1008, 32'h0, 1'b1);
    wr(32'h1014, 32'hCAFE_F00D, 4'b1111);
    rd("e1 ahi", 32'h1014, 32'hCAFE_F00D, 1'b1);
    wr(32'h1030, 32'hFFFF_FFFF, 4'b1111);
    rd("alo lsb", 32'h1030, 32'hFFFF_FFFC, 1'b1);
    wr(32'h1028, 32'h1357_9BDF, 4'b1100);
    rd("e2 dat", 32'h1028, 32'h1357_0000, 1'b1);
    wr(32'h2000, 32'hFFFF_FFFF, 4'b1111);
    rd("pba ro", 32'h2000, 32'h0, 1'b1);
    rd("pba dw1", 32'h2004, 32'h0, 1'b1);
    rd("pba end", 32'h2008, 32'h0, 1'b0);
    wr(32'h3000, 32'h1111_1111, 4'b1111);
    rd("miss", 32'h3000, 32'h0, 1'b0);

    // Masked vector stays pending, unmask sends it
    @(negedge clk);
    dut.trigger_interrupt(11'd2);
    cycles(3);
    check("masked irq", 32'(msix_interrupt), 32'd0);
    rd("pba v2", 32'h2000, 32'h4, 1'b1);
    wr(32'h102C, 32'h0, 4'b1111);
    check("unmask lat", 32'(msix_interrupt), 32'd0);
    @(negedge clk);
    check("unmask irq", 32'(msix_interrupt), 32'd1);
    check("unmask vec", 32'(msix_vector), 32'd2);
    ack();
    check("ack drop", 32'(msix_interrupt), 32'd0);
    rd("pba clr", 32'h2000, 32'h0, 1'b1);

    // Priority and hold-while-waiting
    wr(32'h101C, 32'h0, 4'b1111);
    wr(32'h103C, 32'h0, 4'b1111);
    @(negedge clk);
    dut.trigger_interrupt(11'd1);
    dut.trigger_interrupt(11'd3);
    wait_irq("prio1", 11'd1);
    msix_function_mask = 1'b1;
    wr(32'h101C, 32'h1, 4'b1111);
    check("hold irq", 32'(msix_interrupt), 32'd1);
    check("hold vec", 32'(msix_vector), 32'd1);
    msix_function_mask = 1'b0;
    wr(32'h101C, 32'h0, 4'b1111);
    ack();
    check("gap low", 32'(msix_interrupt), 32'd0);
    @(negedge clk);
    check("prio3 irq", 32'(msix_interrupt), 32'd1);
    check("prio3 vec", 32'(msix_vector), 32'd3);
    ack();

    // Enable / function-mask blocking
    msix_enable = 1'b0;
    wr(32'h100C, 32'h0, 4'b0001);
    dut.trigger_interrupt(11'd0);
    cycles(3);
    check("disabled", 32'(msix_interrupt), 32'd0);
    msix_enable        = 1'b1;
    msix_function_mask = 1'b1;
    cycles(3);
    check("fmasked", 32'(msix_interrupt), 32'd0);
    rd("pba blk", 32'h2000, 32'h1, 1'b1);
    msix_function_mask = 1'b0;
    wait_irq("release", 11'd0);

    // Trigger coinciding with ack: set wins
    @(negedge clk);
    msix_interrupt_ack = 1'b1;
    dut.trigger_interrupt(11'd0);
    @(negedge clk);
    msix_interrupt_ack = 1'b0;
    check("coll low", 32'(msix_interrupt), 32'd0);
    rd("coll pba", 32'h2000, 32'h1, 1'b1);
    @(negedge clk);
    check("coll irq", 32'(msix_interrupt), 32'd1);
    check("coll vec", 32'(msix_vector), 32'd0);
    ack();
    rd("coll clr", 32'h2000, 32'h0, 1'b1);

    // Out-of-range trigger
    dut.trigger_interrupt(11'(N));
    cycles(3);
    check("oor irq", 32'(msix_interrupt), 32'd0);
    rd("oor pba", 32'h2000, 32'h0, 1'b1);

    // Ack while idle is harmless
    ack();
    check("idle ack", 32'(msix_interrupt), 32'd0);

    // Reset mid-request
    dut.trigger_interrupt(11'd1);
    wait_irq("pre rst", 11'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid rst irq", 32'(msix_interrupt), 32'd0);
    check("mid rst vec", 32'(msix_vector), 32'd0);
    rd("mid rst pba", 32'h2000, 32'h0, 1'b1);
    rd("mid rst vct", 32'h101C, 32'h1, 1'b1);
    rd("mid rst ahi", 32'h1014, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/msix_table.md
Name: msix_table

Overview:
- MSI-X table and Pending Bit Array (PBA) endpoint, memory-mapped into a PCIe BAR. Instantiated by the BAR controller next to the config-space shadow.
- Decodes BAR accesses that fall in the table or PBA window and provides register read and write.
- Keeps per-vector pending bits and issues one MSI-X request at a time to the PCIe core, using a request/acknowledge handshake.

Parameters:
- NUM_MSIX, 1: number of table entries; legal range 1..2048.
- MSIX_TABLE_BIR, 0: BAR index that holds the table.
- MSIX_TABLE_OFFSET, 0: byte offset of the table in that BAR; 8-byte aligned.
- MSIX_PBA_BIR, 0: BAR index that holds the PBA.
- MSIX_PBA_OFFSET, 0: byte offset of the PBA in that BAR; 8-byte aligned.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  reset, synchronous to clk, active-low.
- bar_addr  in  32  byte address within the BAR; bits [1:0] ignored.
- bar_index  in  3  BAR number of the current access.
- bar_wr_data  in  32  write data.
- bar_wr_en  in  1  write strobe, one cycle per dword.
- bar_wr_be  in  4  byte enables for the write.
- bar_rd_en  in  1  read strobe; has no side effects.
- bar_rd_data  out  32  read data, combinational.
- bar_access_match  out  1  combinational; asserted when the address hits the table or PBA window.
- msix_enable  in  1  MSI-X Enable bit from the capability.
- msix_function_mask  in  1  Function Mask bit from the capability.
- msix_interrupt  out  1  interrupt request to the PCIe core.
- msix_vector  out  11  vector number being requested.
- msix_interrupt_ack  in  1  one-cycle acknowledge from the core.

Behaviour:
Windows:
- Table hit: bar_index==MSIX_TABLE_BIR and MSIX_TABLE_OFFSET <= addr < MSIX_TABLE_OFFSET+16*NUM_MSIX.
- PBA hit: bar_index==MSIX_PBA_BIR and MSIX_PBA_OFFSET <= addr < MSIX_PBA_OFFSET+8*ceil(NUM_MSIX/64).
- If the two windows overlap, the table takes priority.
- bar_access_match = table hit OR PBA hit.

Table entry layout (per entry: index = (addr-offset)>>4, dword = addr[3:2]):
- Dword 0: message address low. Bits [1:0] read as 0 and are not writable.
- Dword 1: message address high.
- Dword 2: message data.
- Dword 3: vector control. Bit 0 is Mask; bits [31:1] read 0 and writes to them are ignored.

Table reads and writes:
- Reads are combinational from the current register state.
- Writes take effect at the posedge when bar_wr_en and a table hit coincide, byte-merged per bar_wr_be.
- A write with bar_wr_be==0 changes nothing.

PBA:
- PBA dword k returns pending[32k+31:32k]; bits at or above NUM_MSIX read 0.
- PBA is read-only; writes to it are ignored.

Misses:
- bar_rd_data = 0 and bar_access_match = 0.
- Writes outside both windows are ignored.

Reset (reset_n low at posedge):
- All address and data registers = 0.
- All Mask bits = 1.
- pending = 0.
- msix_interrupt = 0, msix_vector = 0.
- State = IDLE.
- Reset mid-request aborts the request immediately.

Trigger:
- The module provides the task trigger_interrupt(input logic [10:0] vector).
- The task raises a request that sets pending[vector] at the next posedge.
- vector >= NUM_MSIX is ignored.
- A trigger on an already-pending vector has no further effect.

Sender FSM:
- IDLE:
  - When msix_enable=1, msix_function_mask=0, and some vector v has pending=1 and Mask=0, select the lowest such v.
  - At the next posedge: msix_interrupt<=1, msix_vector<=v, go to WAIT_ACK.
  - Latency: pending set at edge N gives msix_interrupt high after edge N+1.
- WAIT_ACK:
  - msix_interrupt and msix_vector are held stable until msix_interrupt_ack.
  - A change to enable, function mask or per-vector mask while waiting does not withdraw the request.
  - On ack: msix_interrupt<=0, pending[v]<=0, return to IDLE.
  - Ack while in IDLE is ignored.
  - The earliest next request is one cycle after returning to IDLE, so msix_interrupt is low for at least one cycle between requests.
- Trigger of v in the same cycle that ack clears v: set wins, pending[v] stays 1.
- Masked or disabled vectors stay pending; they are sent once unmasked or enabled.
- A Mask write takes effect for arbitration at the cycle after the write.

Decomposition:
- Package msix_pkg holds:
  - entry dword offset constants (ADDR_LO=0, ADDR_HI=1, DATA=2, VCTRL=3);
  - VCTRL_MASK_BIT=0;
  - entry stride 16, PBA qword stride 8;
  - the sender state enum {IDLE, WAIT_ACK}.
- No sub-module. A lowest-set-bit priority-encoder function lives in the package.

Test Plan:
- Reset, then read entry 0 dwords 0..3 and PBA dword 0 -> 0, 0, 0, 0x00000001, 0x00000000; bar_access_match=1 for each read.
- NUM_MSIX=4, TABLE_OFFSET=0x1000: write 0xFEE01234 to 0x1000 with be=4'b0011, then read -> 0x00001234. Read 0x1040 (end of table) -> match=0, data 0.
- Trigger vector 2 with Mask=1 -> PBA reads 0x4 and msix_interrupt stays 0. Write VCTRL(2)=0 -> msix_interrupt=1 and msix_vector=2 two cycles later. Ack -> interrupt drops next cycle and PBA reads 0.
- Unmask vectors 1 and 3, trigger both in one cycle -> vector 1 is sent first. After ack, one low cycle, then vector 3 is sent.
- msix_enable=0 or msix_function_mask=1 with vector 0 pending and unmasked -> no request. Release the block -> request issues.
- Trigger vector 0 in the same cycle as the ack for vector 0 -> pending stays 1 and a second request follows. Trigger vector NUM_MSIX -> ignored.
